// File: rtl/pe_relay_wn_if.sv
// Handshake bundle for the west/north relay PE: one input and one output link per direction
// plus the per-direction FIFO occupancy.
interface pe_relay_wn_if #(
  parameter int WEST_WIDTH  = 130,
  parameter int NORTH_WIDTH = 130,
  parameter int ADDR_BITS   = 2
);
  logic [WEST_WIDTH-1:0]  in_from_west;
  logic                   in_from_west_valid;
  logic                   in_from_west_ready;
  logic [WEST_WIDTH-1:0]  out_to_west;
  logic                   out_to_west_valid;
  logic                   out_to_west_ready;
  logic [NORTH_WIDTH-1:0] in_from_north;
  logic                   in_from_north_valid;
  logic                   in_from_north_ready;
  logic [NORTH_WIDTH-1:0] out_to_north;
  logic                   out_to_north_valid;
  logic                   out_to_north_ready;
  logic [ADDR_BITS:0]     west_count;
  logic [ADDR_BITS:0]     north_count;

  modport slave (
    input  in_from_west, in_from_west_valid, out_to_west_ready,
    input  in_from_north, in_from_north_valid, out_to_north_ready,
    output in_from_west_ready, out_to_west, out_to_west_valid,
    output in_from_north_ready, out_to_north, out_to_north_valid,
    output west_count, north_count
  );

  modport master (
    output in_from_west, in_from_west_valid, out_to_west_ready,
    output in_from_north, in_from_north_valid, out_to_north_ready,
    input  in_from_west_ready, out_to_west, out_to_west_valid,
    input  in_from_north_ready, out_to_north, out_to_north_valid,
    input  west_count, north_count
  );
endinterface

// File: rtl/pe_relay_wn.sv
// West/north relay PE: two independent first-word-fall-through FIFOs whose draining is gated
// by ap_start while filling continues, so a stalled tile buffers DEPTH words per direction.
module pe_relay_wn_fifo #(
  parameter int WIDTH     = 130,
  parameter int ADDR_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ap_start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_BITS:0] count
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = (ADDR_BITS > 0) ? ADDR_BITS : 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [ADDR_BITS:0] count_q;
  logic               push;
  logic               pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on registered occupancy, never on the consumer side.
  assign in_ready  = (count_q < (ADDR_BITS + 1)'(DEPTH));
  assign out_valid = ap_start & (count_q != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_BITS + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_BITS + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module pe_relay_wn #(
  parameter int WEST_WIDTH  = 130,
  parameter int NORTH_WIDTH = 130,
  parameter int ADDR_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ap_start,
  pe_relay_wn_if.slave    bus
);
  pe_relay_wn_fifo #(
    .WIDTH     (WEST_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_west (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (bus.in_from_west),
    .in_valid  (bus.in_from_west_valid),
    .in_ready  (bus.in_from_west_ready),
    .out_data  (bus.out_to_west),
    .out_valid (bus.out_to_west_valid),
    .out_ready (bus.out_to_west_ready),
    .count     (bus.west_count)
  );

  pe_relay_wn_fifo #(
    .WIDTH     (NORTH_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_north (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (bus.in_from_north),
    .in_valid  (bus.in_from_north_valid),
    .in_ready  (bus.in_from_north_ready),
    .out_data  (bus.out_to_north),
    .out_valid (bus.out_to_north_valid),
    .out_ready (bus.out_to_north_ready),
    .count     (bus.north_count)
  );
endmodule
